// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath width, ResultSrc encodings,
// field widths, and the packed control bundle carried by the ID/EX and EX/MEM registers.
// No ports; imported by the pipeline registers.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int ALU_CTL_W = 3;
  localparam int REG_IDX_W = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 alu_src;
    logic [1:0]           result_src;
    logic [ALU_CTL_W-1:0] alu_control;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // All-zero bundle: no write, no memory access, no control transfer.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register with async reset, synchronous clear and enable.
// Ports: clk, rst_n (async active-low), en (load d), clr (load RST_VAL, beats en), d, q.
// Latency 1 cycle; priority reset > clr > en > hold.
module pipe_field_reg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded control, operands, immediates and
// register indices from Decode and presents them to Execute one cycle later.
// Ports: clk, rst_n (async active-low), EnE (load/hold), FlushE (bubble, beats EnE),
//   *D inputs -> matching *E registered outputs, ValidD -> ValidE, BubbleCountE.
// Optional macro ID_EX_BUBBLE_CNT_EN adds a saturating count of flushed edges
// on BubbleCountE; without it BubbleCountE is tied to zero (same port list).
module id_ex_reg
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 EnE,
  input  logic                 FlushE,
  input  logic                 ValidD,
  input  logic                 RegWriteD,
  input  logic                 MemWriteD,
  input  logic                 JumpD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic [1:0]           ResultSrcD,
  input  logic [ALU_CTL_W-1:0] ALUControlD,
  input  logic [XLEN-1:0]      RD1D,
  input  logic [XLEN-1:0]      RD2D,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      ImmExtD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic [REG_IDX_W-1:0] Rs1D,
  input  logic [REG_IDX_W-1:0] Rs2D,
  input  logic [REG_IDX_W-1:0] RdD,
  output logic                 ValidE,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic                 ALUSrcE,
  output logic [1:0]           ResultSrcE,
  output logic [ALU_CTL_W-1:0] ALUControlE,
  output logic [XLEN-1:0]      RD1E,
  output logic [XLEN-1:0]      RD2E,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      ImmExtE,
  output logic [XLEN-1:0]      PCPlus4E,
  output logic [REG_IDX_W-1:0] Rs1E,
  output logic [REG_IDX_W-1:0] Rs2E,
  output logic [REG_IDX_W-1:0] RdE,
  output logic [31:0]          BubbleCountE
);

  localparam int IDX3_W = 3 * REG_IDX_W;

  ctrl_t              ctrl_d, ctrl_q;
  logic [IDX3_W-1:0]  idx_d, idx_q;

  assign ctrl_d = '{reg_write:   RegWriteD,
                    mem_write:   MemWriteD,
                    jump:        JumpD,
                    branch:      BranchD,
                    alu_src:     ALUSrcD,
                    result_src:  ResultSrcD,
                    alu_control: ALUControlD};

  assign idx_d = {Rs1D, Rs2D, RdD};

  // Bubble value equals reset value (all zero); zeroed indices keep the
  // hazard unit's x1..x31 compares from matching a bubble.
  pipe_field_reg #(.WIDTH(CTRL_W), .RST_VAL(CTRL_BUBBLE)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(ctrl_d), .q(ctrl_q));

  pipe_field_reg #(.WIDTH(XLEN)) u_rd1 (
    .clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(RD1D), .q(RD1E));

  pipe_field_reg #(.WIDTH(XLEN)) u_rd2 (
    .clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(RD2D), .q(RD2E));

  pipe_field_reg #(.WIDTH(XLEN)) u_pc (
    .clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(PCD), .q(PCE));

  pipe_field_reg #(.WIDTH(XLEN)) u_imm (
    .clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(ImmExtD), .q(ImmExtE));

  pipe_field_reg #(.WIDTH(XLEN)) u_pc4 (
    .clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(PCPlus4D), .q(PCPlus4E));

  pipe_field_reg #(.WIDTH(IDX3_W)) u_idx (
    .clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(idx_d), .q(idx_q));

  pipe_field_reg #(.WIDTH(1)) u_valid (
    .clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(ValidD), .q(ValidE));

  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUControlE = ctrl_q.alu_control;
  assign {Rs1E, Rs2E, RdE} = idx_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;

  // Counts every flushed edge regardless of EnE; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= 32'h0;
    end else if (FlushE && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'h1;
    end
  end

  assign BubbleCountE = bubble_cnt;
`else
  assign BubbleCountE = 32'h0;
`endif

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the RV32I 5-stage core. It captures decoded control, register-file read data, immediates and register indices from Decode, and presents them to Execute. Its RD1E/RD2E outputs feed the EX forwarding muxes, and its Rs1E/Rs2E/RdE outputs feed the hazard unit. It supports hold (stall), bubble insertion (flush), a per-stage valid bit and an optional bubble counter.

## Interface
- XLEN, 32, datapath width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- EnE  in  1  1 = load new Decode values; 0 = hold current contents
- FlushE  in  1  1 = insert bubble next edge; overrides EnE
- ValidD  in  1  Decode holds a real instruction
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  control bits
- ResultSrcD  in  2  00 ALU, 01 memory, 10 PC+4
- ALUControlD  in  3  ALU operation
- RD1D, RD2D, PCD, ImmExtD, PCPlus4D  in  XLEN each  data fields
- Rs1D, Rs2D, RdD  in  5 each  register indices
- Every D-suffixed input has a matching E-suffixed output of the same width (RegWriteE … RdE), plus ValidE  out  1
- BubbleCountE  out  32  number of bubbles inserted (see Configuration)

## Operation
- Single register bank, updated only on rising clk or falling rst_n.
- Per edge, in priority order:
  - rst_n=0: clear everything.
  - FlushE=1: load the bubble.
  - EnE=1: load the D inputs.
  - Otherwise: hold.
- Bubble / reset value:
  - All control outputs 0 (RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE).
  - ResultSrcE=00, ALUControlE=000, ValidE=0.
  - All data outputs 0.
  - Rs1E=Rs2E=RdE=0, so a bubble never matches a forwarding or load-use compare against x1..x31.
- Loaded fields copy the D inputs bit-exact. ValidE=ValidD.
- FlushE=1 with EnE=0 still flushes: flush wins over hold.
- Hold with ValidE=1 keeps every field, including RD1E/RD2E. Forwarding for the held instruction is re-evaluated downstream each cycle.
- rst_n asserted mid-operation clears immediately, with no clock needed. After release, the first loading edge behaves normally.
- No arithmetic on the data path. Widths pass through unchanged.

## Timing
- Latency: exactly 1 cycle from D inputs to E outputs.
- Outputs are registered only, with no combinational path from input to output.
- FlushE and EnE are sampled on the same edge as the data.
- Back-to-back flushes produce consecutive bubbles. A load on the cycle after a flush is allowed.
- The bubble counter updates on the same edge that inserts the bubble.

## Configuration
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - 32-bit counter reset to 0.
  - Increments on every edge where rst_n=1 and FlushE=1.
  - Saturates at 0xFFFFFFFF.
  - Not affected by EnE.
  - Drives BubbleCountE.
- Undefined:
  - No counter flops.
  - BubbleCountE is tied to 32'h0.
  - The port list is identical in both builds.

## Structure
- Shared package riscv_pkg holds:
  - XLEN.
  - ResultSrc encodings (RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10).
  - ALUControl width.
  - Register-index width (5).
  - A packed control-bundle typedef used by the ID/EX and EX/MEM registers.
- One sub-module, pipe_field_reg:
  - Parameterised width and reset value.
  - Inputs clk, rst_n, en, clr, d; output q.
  - Priority: reset > clr > en.
- id_ex_reg instantiates pipe_field_reg once per field group: control bundle, each data word, indices, valid.

## Test plan
- Reset: drive nonzero inputs with rst_n=0 and no clock edge → every output 0, BubbleCountE=0.
- Load: RD1D=0x12345678, RdD=5, RegWriteD=1, ResultSrcD=01, EnE=1 → next edge RD1E=0x12345678, RdE=5, RegWriteE=1, ResultSrcE=01, ValidE=1.
- Hold: after the load, EnE=0 for 3 cycles while inputs change to 0xFFFFFFFF → outputs stay 0x12345678/5 for all 3 cycles.
- Flush precedence: valid stage, FlushE=1 and EnE=0 → next edge ValidE=0, RegWriteE=0, RdE=0, RD1E=0. With the macro defined, BubbleCountE=1.
- Async reset mid-stream: assert rst_n=0 between edges while ValidE=1 → outputs 0 before the next edge. Release, then load RdD=7 → RdE=7 one edge later.
- Counter saturation (macro defined): force counter to 0xFFFFFFFE, flush 3 cycles → 0xFFFFFFFF and stays. Macro undefined: BubbleCountE=0 throughout.
